// File: rtl/onehot_pulse_decoder_if.sv
// Index handshake between an upstream channel-index source and the pulse decoder.
interface onehot_pulse_decoder_if #(
    parameter int N_IN = 4
);
    logic            in_valid;
    logic [N_IN-1:0] in_code;
    logic            in_ready;

    modport master (
        output in_valid,
        output in_code,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_code,
        output in_ready
    );
endinterface

// File: rtl/onehot_pulse_decoder.sv
// Sequential 4-to-16 one-hot decoder: strobes line y[code] for PULSE_LEN cycles,
// then holds y idle for GAP_LEN cycles before accepting the next index.
module onehot_pulse_decoder #(
    parameter int N_IN      = 4,
    parameter int PULSE_LEN = 4,
    parameter int GAP_LEN   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    onehot_pulse_decoder_if.slave in_if,
    output logic [2**N_IN-1:0]   y,
    output logic                 busy,
    output logic                 done
);
    localparam int OUT_W = 2**N_IN;
    localparam int MAX_LEN = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
    localparam int CNT_W = $clog2(MAX_LEN + 1);
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_LEN - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = (GAP_LEN > 0) ? CNT_W'(GAP_LEN - 1) : '0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N_IN-1:0]  code_q, code_d;
    logic [OUT_W-1:0] y_q, y_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             xfer;

    // Gated by rst so upstream never sees a ready while the block is held in reset.
    assign in_if.in_ready = (state_q == IDLE) && en && !rst;
    assign xfer           = in_if.in_valid && in_if.in_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        y_d     = y_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        if (!en) begin
            // Abort takes priority over a pulse ending this cycle, so done stays low.
            state_d = IDLE;
            cnt_d   = '0;
            y_d     = '0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (xfer) begin
                        state_d = DRIVE;
                        code_d  = in_if.in_code;
                        y_d     = OUT_W'(1) << in_if.in_code;
                        busy_d  = 1'b1;
                        cnt_d   = PULSE_LOAD;
                    end
                end
                DRIVE: begin
                    if (cnt_q == '0) begin
                        y_d    = '0;
                        done_d = 1'b1;
                        cnt_d  = GAP_LOAD;
                        if (GAP_LEN > 0) begin
                            state_d = GAP;
                        end else begin
                            state_d = IDLE;
                            busy_d  = 1'b0;
                        end
                    end else begin
                        y_d   = OUT_W'(1) << code_q;
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                GAP: begin
                    y_d = '0;
                    if (cnt_q == '0) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    y_d     = '0;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            code_q  <= '0;
            y_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            y_q     <= y_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign y    = y_q;
    assign busy = busy_q;
    assign done = done_q;
endmodule
